// File: rtl/reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue
//   Write side of the 32x32 register file. Load results (Mem, older) and ALU
//   results (Alu, younger) are queued in program order and drained to the
//   register file write port at one write per cycle. A combinational lookup
//   returns the youngest pending value for a register so that decode can
//   forward it.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   Mem_valid/_reg/_data/_ready   load result handshake (older source)
//   Alu_valid/_reg/_data/_ready   ALU result handshake (younger source)
//   RegWrite/Write_reg/Write_data registered register-file write port
//   Lookup_reg/_hit/_data         pending-write lookup for decode
//   Occupancy                     entries currently queued
// ---------------------------------------------------------------------------
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Mem_valid,
    input  logic [ADDR_W-1:0] Mem_reg,
    input  logic [DATA_W-1:0] Mem_data,
    output logic              Mem_ready,
    input  logic              Alu_valid,
    input  logic [ADDR_W-1:0] Alu_reg,
    input  logic [DATA_W-1:0] Alu_data,
    output logic              Alu_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_reg,
    output logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] Lookup_reg,
    output logic              Lookup_hit,
    output logic [DATA_W-1:0] Lookup_data,
    output logic [CNT_W-1:0]  Occupancy
);

    logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, alu_slot;
    logic [CNT_W-1:0]  count_q, count_d, free, enq_cnt;
    logic              regwrite_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic              mem_store, alu_store, pop;
    logic [PTR_W-1:0]  lk_idx;

    // Readiness depends on the registered count only; a pop on the same edge
    // does not create room for this cycle's offers.
    assign free      = CNT_W'(DEPTH) - count_q;
    assign Mem_ready = (free >= CNT_W'(1));
    assign Alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !Mem_valid);

    // r0 destinations complete the handshake but are never stored.
    assign mem_store = Mem_valid && Mem_ready && (Mem_reg != '0);
    assign alu_store = Alu_valid && Alu_ready && (Alu_reg != '0);
    assign pop       = (count_q != '0);

    assign enq_cnt  = CNT_W'(mem_store) + CNT_W'(alu_store);
    assign alu_slot = mem_store ? tail_q + PTR_W'(1) : tail_q;
    assign tail_d   = tail_q + PTR_W'(enq_cnt);
    assign head_d   = pop ? head_q + PTR_W'(1) : head_q;
    assign count_d  = count_q + enq_cnt - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            // Only free slots are written, so neither slot can alias the head.
            if (mem_store) begin
                ent_reg_q[tail_q]  <= Mem_reg;
                ent_data_q[tail_q] <= Mem_data;
            end
            if (alu_store) begin
                ent_reg_q[alu_slot]  <= Alu_reg;
                ent_data_q[alu_slot] <= Alu_data;
            end
            regwrite_q <= pop;
            if (pop) begin
                write_reg_q  <= ent_reg_q[head_q];
                write_data_q <= ent_data_q[head_q];
            end
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign Write_reg  = write_reg_q;
    assign Write_data = write_data_q;
    assign Occupancy  = count_q;

    // Youngest match wins: the write port is checked first, then the queue from
    // head (oldest) to tail (youngest), each later match overriding.
    always_comb begin
        Lookup_hit  = 1'b0;
        Lookup_data = '0;
        lk_idx      = '0;
        if (regwrite_q && (write_reg_q == Lookup_reg)) begin
            Lookup_hit  = 1'b1;
            Lookup_data = write_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (ent_reg_q[lk_idx] == Lookup_reg)) begin
                Lookup_hit  = 1'b1;
                Lookup_data = ent_data_q[lk_idx];
            end
        end
        if (Lookup_reg == '0) begin
            Lookup_hit  = 1'b0;
            Lookup_data = '0;
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

    logic        clk;
    logic        rst_n;
    logic        Mem_valid, Alu_valid;
    logic [4:0]  Mem_reg, Alu_reg, Lookup_reg;
    logic [31:0] Mem_data, Alu_data;
    logic        Mem_ready, Alu_ready;
    logic        RegWrite;
    logic [4:0]  Write_reg;
    logic [31:0] Write_data;
    logic        Lookup_hit;
    logic [31:0] Lookup_data;
    logic [2:0]  Occupancy;

    int errors = 0;
    int checks = 0;

    logic [36:0] wr_log[$];
    logic [36:0] wr_exp[$];

    reg_writeback_queue dut (
        .clk(clk), .rst_n(rst_n),
        .Mem_valid(Mem_valid), .Mem_reg(Mem_reg), .Mem_data(Mem_data), .Mem_ready(Mem_ready),
        .Alu_valid(Alu_valid), .Alu_reg(Alu_reg), .Alu_data(Alu_data), .Alu_ready(Alu_ready),
        .RegWrite(RegWrite), .Write_reg(Write_reg), .Write_data(Write_data),
        .Lookup_reg(Lookup_reg), .Lookup_hit(Lookup_hit), .Lookup_data(Lookup_data),
        .Occupancy(Occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each write is visible for exactly one cycle; capture it mid-cycle.
    always @(negedge clk) begin
        if (rst_n && RegWrite) wr_log.push_back({Write_reg, Write_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Mem_valid = 1'b0; Mem_reg = '0; Mem_data = '0;
        Alu_valid = 1'b0; Alu_reg = '0; Alu_data = '0;
    endtask

    task automatic look(input string tag, input logic [4:0] r, input logic hit, input logic [31:0] d);
        Lookup_reg = r;
        #1;
        chk({tag, "_hit"}, 64'(Lookup_hit), 64'(hit));
        chk({tag, "_data"}, 64'(Lookup_data), 64'(d));
    endtask

    task automatic compare_log(input string tag);
        chk({tag, "_count"}, 64'(wr_log.size()), 64'(wr_exp.size()));
        for (int i = 0; i < wr_exp.size(); i++) begin
            if (i < wr_log.size()) chk($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), 64'(wr_exp[i]));
        end
    endtask

    int  mcnt;
    int  mfree;
    logic em, ea;

    initial begin
        rst_n = 1'b0;
        Lookup_reg = '0;
        idle_inputs();
        #2;
        chk("rst_occ", 64'(Occupancy), 64'd0);
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_occ", 64'(Occupancy), 64'd0);
        chk("post_rst_regwrite", 64'(RegWrite), 64'd0);
        chk("post_rst_wreg", 64'(Write_reg), 64'd0);
        chk("post_rst_wdata", 64'(Write_data), 64'd0);
        chk("post_rst_mem_ready", 64'(Mem_ready), 64'd1);
        chk("post_rst_alu_ready", 64'(Alu_ready), 64'd1);

        // Single ALU write r5 = 0xAA
        Alu_valid = 1'b1; Alu_reg = 5'd5; Alu_data = 32'h0000_00AA;
        tick();
        idle_inputs();
        chk("single_occ1", 64'(Occupancy), 64'd1);
        chk("single_nowrite_yet", 64'(RegWrite), 64'd0);
        look("single_lk_queued", 5'd5, 1'b1, 32'hAA);
        tick();
        chk("single_regwrite", 64'(RegWrite), 64'd1);
        chk("single_wreg", 64'(Write_reg), 64'd5);
        chk("single_wdata", 64'(Write_data), 64'hAA);
        chk("single_occ0", 64'(Occupancy), 64'd0);
        look("single_lk_port", 5'd5, 1'b1, 32'hAA);
        tick();
        chk("single_regwrite_off", 64'(RegWrite), 64'd0);
        chk("single_wreg_hold", 64'(Write_reg), 64'd5);
        look("single_lk_gone", 5'd5, 1'b0, 32'h0);

        // Same-cycle Mem and Alu to r3: Mem is older
        Mem_valid = 1'b1; Mem_reg = 5'd3; Mem_data = 32'h11;
        Alu_valid = 1'b1; Alu_reg = 5'd3; Alu_data = 32'h22;
        tick();
        idle_inputs();
        chk("order_occ2", 64'(Occupancy), 64'd2);
        look("order_lk_both", 5'd3, 1'b1, 32'h22);
        tick();
        chk("order_w1", {RegWrite, Write_reg, Write_data}, {1'b1, 5'd3, 32'h11});
        look("order_lk_mid", 5'd3, 1'b1, 32'h22);
        tick();
        chk("order_w2", {RegWrite, Write_reg, Write_data}, {1'b1, 5'd3, 32'h22});
        look("order_lk_port", 5'd3, 1'b1, 32'h22);
        tick();
        chk("order_idle", 64'(RegWrite), 64'd0);

        // r0 destination is accepted but discarded
        wr_log.delete();
        Alu_valid = 1'b1; Alu_reg = 5'd0; Alu_data = 32'hDEAD;
        #1;
        chk("r0_ready", 64'(Alu_ready), 64'd1);
        tick();
        idle_inputs();
        chk("r0_occ", 64'(Occupancy), 64'd0);
        look("r0_lk", 5'd0, 1'b0, 32'h0);
        tick();
        tick();
        chk("r0_nowrite", 64'(wr_log.size()), 64'd0);

        // Full: both sources valid every cycle with draining active
        wr_log.delete();
        wr_exp.delete();
        mcnt = 0;
        for (int k = 0; k < 6; k++) begin
            Mem_valid = 1'b1; Mem_reg = 5'(8 + k);  Mem_data = 32'h100 + 32'(k);
            Alu_valid = 1'b1; Alu_reg = 5'(16 + k); Alu_data = 32'h200 + 32'(k);
            #1;
            mfree = 4 - mcnt;
            em = (mfree >= 1);
            ea = (mfree >= 2);
            chk($sformatf("full_mem_ready%0d", k), 64'(Mem_ready), 64'(em));
            chk($sformatf("full_alu_ready%0d", k), 64'(Alu_ready), 64'(ea));
            if (em) wr_exp.push_back({Mem_reg, Mem_data});
            if (ea) wr_exp.push_back({Alu_reg, Alu_data});
            tick();
            mcnt = mcnt + int'(em) + int'(ea) - ((mcnt > 0) ? 1 : 0);
            chk($sformatf("full_occ%0d", k), 64'(Occupancy), 64'(mcnt));
        end
        chk("full_steady_count3", 64'(mcnt), 64'd3);
        idle_inputs();
        repeat (5) tick();
        compare_log("full");

        // Wrap: 12 ALU writes r1..r12, data = index
        wr_log.delete();
        wr_exp.delete();
        for (int k = 1; k <= 12; k++) begin
            Alu_valid = 1'b1; Alu_reg = 5'(k); Alu_data = 32'(k);
            wr_exp.push_back({5'(k), 32'(k)});
            tick();
        end
        idle_inputs();
        chk("wrap_occ_tail", 64'(Occupancy), 64'd1);
        repeat (3) tick();
        compare_log("wrap");
        chk("wrap_empty", 64'(Occupancy), 64'd0);

        // Async reset mid-burst with 3 entries queued
        Mem_valid = 1'b1; Mem_reg = 5'd20; Mem_data = 32'h20;
        Alu_valid = 1'b1; Alu_reg = 5'd21; Alu_data = 32'h21;
        tick();
        Mem_reg = 5'd22; Mem_data = 32'h22;
        Alu_reg = 5'd23; Alu_data = 32'h23;
        tick();
        idle_inputs();
        chk("burst_occ3", 64'(Occupancy), 64'd3);
        chk("burst_writing", 64'(RegWrite), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_occ", 64'(Occupancy), 64'd0);
        chk("async_rst_regwrite", 64'(RegWrite), 64'd0);
        chk("async_rst_wreg", 64'(Write_reg), 64'd0);
        wr_log.delete();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("after_rst_nowrite", 64'(wr_log.size()), 64'd0);
        chk("after_rst_occ", 64'(Occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
